// File: rtl/boot_frame_decoder_if.sv
// Purpose: bundles the byte-receive input and the ICCM write / status
//          outputs of the boot frame decoder into one interface.
// Signals (named from the decoder's point of view):
//   rx_dv_i    one-cycle pulse, rx_byte_i valid
//   rx_byte_i  received byte
//   we_o       one-cycle ICCM write strobe
//   addr_o     ICCM word address for we_o
//   wdata_o    ICCM write data
//   core_rst_o 1 = hold core in reset
//   busy_o     1 = frame in progress
//   err_o      sticky error flag
// Modports: master = byte source / observer, slave = decoder.
interface boot_frame_decoder_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              rx_dv_i;
  logic [7:0]        rx_byte_i;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              err_o;

  modport master (
    output rx_dv_i, rx_byte_i,
    input  we_o, addr_o, wdata_o, core_rst_o, busy_o, err_o
  );

  modport slave (
    input  rx_dv_i, rx_byte_i,
    output we_o, addr_o, wdata_o, core_rst_o, busy_o, err_o
  );
endinterface

// File: rtl/boot_frame_decoder.sv
// Purpose: parses framed boot packets from the UART byte stream into ICCM
//          word writes and a core-hold-in-reset control.
// Frame: SYNC CMD [AHI ALO LEN payload(LEN*4, LE words)] CHK
//        CMD 01 = WRITE, 02 = RUN; CHK = XOR of CMD .. byte before CHK.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     boot_frame_decoder_if.slave (byte input, write/status outputs)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | hunting for SYNC_BYTE, other bytes dropped
// CMD   | waiting for command byte
// AHI   | waiting for address high byte
// ALO   | waiting for address low byte
// LEN   | waiting for word count (0 = 256)
// DATA  | assembling payload words, one write per 4 bytes
// CHK   | waiting for checksum byte
module boot_frame_decoder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  boot_frame_decoder_if.slave bus
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       CMD_WR   = 8'h01;
  localparam logic [7:0]       CMD_RUN  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_AHI, S_ALO, S_LEN, S_DATA, S_CHK
  } state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [7:0]        ahi_q, ahi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              we_q, we_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      ahi_q      <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      chk_q      <= '0;
      tmr_q      <= '0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      ahi_q      <= ahi_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      chk_q      <= chk_d;
      tmr_q      <= tmr_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    ahi_d      = ahi_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    chk_d      = chk_q;
    tmr_d      = tmr_q;
    we_d       = 1'b0;
    core_rst_d = core_rst_q;
    err_d      = err_q;

    if (bus.rx_dv_i) begin
      // A byte always restarts the inter-byte timer, even on its expiry cycle.
      tmr_d = TMR_LOAD;
      unique case (state_q)
        S_IDLE: begin
          if (bus.rx_byte_i == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          chk_d = bus.rx_byte_i;
          if (bus.rx_byte_i == CMD_WR) begin
            run_d      = 1'b0;
            core_rst_d = 1'b1;
            state_d    = S_AHI;
          end else if (bus.rx_byte_i == CMD_RUN) begin
            run_d   = 1'b1;
            state_d = S_CHK;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_AHI: begin
          chk_d   = chk_q ^ bus.rx_byte_i;
          ahi_d   = bus.rx_byte_i;
          state_d = S_ALO;
        end
        S_ALO: begin
          chk_d   = chk_q ^ bus.rx_byte_i;
          ptr_d   = ADDR_W'({ahi_q, bus.rx_byte_i});
          state_d = S_LEN;
        end
        S_LEN: begin
          chk_d   = chk_q ^ bus.rx_byte_i;
          wcnt_d  = (bus.rx_byte_i == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte_i};
          bcnt_d  = 2'd0;
          state_d = S_DATA;
        end
        S_DATA: begin
          chk_d  = chk_q ^ bus.rx_byte_i;
          // Shift right so the first byte of a word ends up in [7:0].
          word_d = {bus.rx_byte_i, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = word_d;
            addr_d  = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
            wcnt_d  = wcnt_q - 9'd1;
            if (wcnt_q == 9'd1) state_d = S_CHK;
          end
        end
        S_CHK: begin
          if (bus.rx_byte_i != chk_q) err_d = 1'b1;
          else if (run_q && !err_q)   core_rst_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmr_q == '0) begin
        // Partial word is dropped simply by leaving DATA.
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end
  end

  assign busy_d = (state_d != S_IDLE);

  assign bus.we_o       = we_q;
  assign bus.addr_o     = addr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.core_rst_o = core_rst_q;
  assign bus.busy_o     = busy_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_boot_frame_decoder.sv
module tb_boot_frame_decoder;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  wr_t  exp_q [$];
  wr_t  obs_q [$];
  logic exp_err;
  logic exp_core_rst;

  boot_frame_decoder_if #(.ADDR_W(14)) bus ();

  boot_frame_decoder #(
    .ADDR_W     (14),
    .TIMEOUT_CYC(16),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level reference: derives writes and status from the whole byte list.
  function automatic void model_frame(input bq_t f);
    int n;
    logic [7:0] x;
    int unsigned base;
    int len;
    n = f.size();
    if (n < 2 || f[0] != 8'hA5) return;
    x = 8'h00;
    for (int i = 1; i < n - 1; i++) x ^= f[i];
    if (f[1] == 8'h01) begin
      base = {f[2], f[3]};
      len  = (f[4] == 8'h00) ? 256 : int'(f[4]);
      for (int w = 0; w < len; w++) begin
        wr_t e;
        e.a = 14'((base + w) % 16384);
        e.d = {f[8+4*w], f[7+4*w], f[6+4*w], f[5+4*w]};
        exp_q.push_back(e);
      end
      exp_core_rst = 1'b1;
      if (x != f[n-1]) exp_err = 1'b1;
    end else if (f[1] == 8'h02) begin
      if (x != f[n-1]) exp_err = 1'b1;
      else if (!exp_err) exp_core_rst = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endfunction

  function automatic bq_t build_write(input logic [15:0] a, input logic [7:0] len,
                                      input logic [31:0] w [$], input bit corrupt);
    bq_t f;
    logic [7:0] x;
    f = {8'hA5, 8'h01, a[15:8], a[7:0], len};
    foreach (w[i]) for (int k = 0; k < 4; k++) f.push_back(w[i][8*k +: 8]);
    x = 8'h00;
    for (int i = 1; i < f.size(); i++) x ^= f[i];
    if (corrupt) x = ~x;
    f.push_back(x);
    return f;
  endfunction

  task automatic send_frame(input bq_t f, input int gap);
    foreach (f[i]) begin
      @(negedge clk);
      bus.rx_dv_i   = 1'b1;
      bus.rx_byte_i = f[i];
      repeat (gap) begin
        @(negedge clk);
        bus.rx_dv_i = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_dv_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_dv_i = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_err      = 1'b0;
    exp_core_rst = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err"},      bus.err_o,      exp_err);
    check({tag, "_core_rst"}, bus.core_rst_o, exp_core_rst);
    check({tag, "_busy"},     bus.busy_o,     1'b0);
    check({tag, "_pending"},  exp_q.size(),   0);
  endtask

  // Every write strobe is matched against the model's next expected write.
  always @(negedge clk) begin
    if (rst_n && bus.we_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_we: addr %h data %h, expected no write", bus.addr_o, bus.wdata_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.addr_o !== e.a || bus.wdata_o !== e.d) begin
          fails++;
          $display("FAIL write: got %h/%h expected %h/%h", bus.addr_o, bus.wdata_o, e.a, e.d);
        end
      end
      obs_q.push_back({bus.addr_o, bus.wdata_o});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t f;
    logic [31:0] w [$];
    bus.rx_dv_i   = 1'b0;
    bus.rx_byte_i = 8'h00;
    exp_err       = 1'b0;
    exp_core_rst  = 1'b1;

    // Reset values
    do_reset();
    check("rst_we",       bus.we_o,       1'b0);
    check("rst_addr",     bus.addr_o,     14'h0);
    check("rst_wdata",    bus.wdata_o,    32'h0);
    check("rst_core_rst", bus.core_rst_o, 1'b1);
    check("rst_busy",     bus.busy_o,     1'b0);
    check("rst_err",      bus.err_o,      1'b0);

    // Garbage in IDLE is dropped
    f = {8'h00, 8'hFF, 8'h5A};
    send_frame(f, 0);
    check_status("garbage");

    // WRITE two words at 0x0010, back-to-back bytes, hand-computed CHK 0x57
    f = {8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
         8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h57};
    obs_q.delete();
    model_frame(f);
    send_frame(f, 0);
    check_status("write1");
    check("write1_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("write1_w0", {18'h0, obs_q[0].a}, 32'h0010);
      check("write1_d0", obs_q[0].d, 32'h11223344);
      check("write1_w1", {18'h0, obs_q[1].a}, 32'h0011);
      check("write1_d1", obs_q[1].d, 32'hAABBCCDD);
    end
    check("write1_err_lit", bus.err_o, 1'b0);

    // RUN: core_rst falls one cycle after CHK
    f = {8'hA5, 8'h02, 8'h02};
    model_frame(f);
    f = {8'hA5, 8'h02};
    send_frame(f, 0);
    @(negedge clk);
    bus.rx_dv_i   = 1'b1;
    bus.rx_byte_i = 8'h02;
    check("run_before_chk", bus.core_rst_o, 1'b1);
    @(negedge clk);
    bus.rx_dv_i = 1'b0;
    check("run_after_chk_lit", bus.core_rst_o, 1'b0);
    check_status("run");

    // WRITE across the address wrap, upper address bits ignored, with gaps
    w = {32'hCAFEF00D, 32'h01234567};
    f = build_write(16'h7FFF, 8'd2, w, 1'b0);
    obs_q.delete();
    model_frame(f);
    send_frame(f, 1);
    check_status("wrap");
    if (obs_q.size() == 2) begin
      check("wrap_a0_lit", {18'h0, obs_q[0].a}, 32'h3FFF);
      check("wrap_a1_lit", {18'h0, obs_q[1].a}, 32'h0000);
    end else begin
      check("wrap_count", obs_q.size(), 2);
    end

    // WRITE with bad CHK still writes, then RUN is ignored
    w = {32'hDEADBEEF};
    f = build_write(16'h0200, 8'd1, w, 1'b1);
    model_frame(f);
    send_frame(f, 0);
    check_status("badchk");
    f = {8'hA5, 8'h02, 8'h02};
    model_frame(f);
    send_frame(f, 0);
    check_status("run_after_err");
    check("run_after_err_lit", bus.core_rst_o, 1'b1);

    // Unknown command
    do_reset();
    f = {8'hA5, 8'h07};
    model_frame(f);
    send_frame(f, 0);
    check_status("badcmd");
    check("badcmd_err_lit", bus.err_o, 1'b1);

    // LEN = 0 means 256 words
    do_reset();
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back({i[7:0], ~i[7:0], 8'h5A, i[7:0]});
    f = build_write(16'h0100, 8'd0, w, 1'b0);
    obs_q.delete();
    model_frame(f);
    send_frame(f, 0);
    check_status("len256");
    check("len256_count", obs_q.size(), 256);

    // Inter-byte timeout after A5 01 00
    do_reset();
    f = {8'hA5, 8'h01, 8'h00};
    send_frame(f, 0);
    repeat (15) @(negedge clk);
    check("tmo_busy_before", bus.busy_o, 1'b1);
    check("tmo_err_before",  bus.err_o,  1'b0);
    @(negedge clk);
    check("tmo_busy_after",  bus.busy_o, 1'b0);
    check("tmo_err_after",   bus.err_o,  1'b1);

    // Timeout with a partial word in DATA: no write
    f = {8'hA5, 8'h01, 8'h00, 8'h10, 8'h01, 8'hAA, 8'hBB};
    send_frame(f, 0);
    repeat (15) @(negedge clk);
    check("tmo2_busy_before", bus.busy_o, 1'b1);
    @(negedge clk);
    check("tmo2_busy_after",  bus.busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check("tmo2_pending", exp_q.size(), 0);

    // Reset mid-DATA
    do_reset();
    f = {8'hA5, 8'h01, 8'h00, 8'h20, 8'h01, 8'h11, 8'h22, 8'h33};
    send_frame(f, 0);
    check("middata_busy", bus.busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("middata_we",       bus.we_o,       1'b0);
    check("middata_core_rst", bus.core_rst_o, 1'b1);
    check("middata_busy_rst", bus.busy_o,     1'b0);
    check("middata_err",      bus.err_o,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    f = {8'h44};
    send_frame(f, 0);
    repeat (3) @(negedge clk);
    check("middata_idle", bus.busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
